// File: rtl/blk_1c3d32.sv
// Deadlock report unit: confirms a suspected dataflow deadlock by circulating a
// token from one originator, publishes a single report record, then locks.
module blk_1c3d32 #(
  parameter int unsigned PROC_NUM = 4,
  parameter int unsigned ID_W     = 2,
  parameter int unsigned TIMEOUT  = 64,
  parameter int unsigned CYC_W    = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PROC_NUM-1:0] dl_in_vec,
  output logic                dl_bcast,
  output logic [PROC_NUM-1:0] origin_vec,
  output logic                token_clear,
  output logic                rpt_valid,
  input  logic                rpt_ready,
  output logic [ID_W-1:0]     rpt_proc_id,
  output logic [CYC_W-1:0]    rpt_cycle,
  output logic                deadlock_flag,
  output logic [7:0]          false_alarms,
  input  logic                rearm
);

  localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned FA_W  = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ORIGIN = 3'd1,
    WAIT   = 3'd2,
    REPORT = 3'd3,
    LOCKED = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     cand_q, cand_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [CYC_W-1:0]    cyc_q, cyc_d;
  logic [FA_W-1:0]     false_alarms_q, false_alarms_d;
  logic [ID_W-1:0]     rpt_proc_id_q, rpt_proc_id_d;
  logic [CYC_W-1:0]    rpt_cycle_q, rpt_cycle_d;
  logic                dl_bcast_q, dl_bcast_d;
  logic [PROC_NUM-1:0] origin_vec_q, origin_vec_d;
  logic                rpt_valid_q, rpt_valid_d;
  logic                deadlock_flag_q, deadlock_flag_d;
  logic [ID_W-1:0]     lowest_c;

  // Index of the lowest suspecting process; it becomes the token originator.
  always_comb begin
    lowest_c = '0;
    for (int i = PROC_NUM - 1; i >= 0; i--) begin
      if (dl_in_vec[i]) lowest_c = ID_W'(i);
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d         = state_q;
    cand_d          = cand_q;
    timer_d         = timer_q;
    cyc_d           = cyc_q + CYC_W'(1);
    false_alarms_d  = false_alarms_q;
    rpt_proc_id_d   = rpt_proc_id_q;
    rpt_cycle_d     = rpt_cycle_q;
    token_clear     = 1'b0;

    case (state_q)
      IDLE: begin
        if (|dl_in_vec) begin
          cand_d  = lowest_c;
          state_d = ORIGIN;
        end
      end
      ORIGIN: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A returning token beats a simultaneous timeout.
        if (dl_in_vec[cand_q]) begin
          token_clear   = 1'b1;
          rpt_proc_id_d = cand_q;
          rpt_cycle_d   = cyc_q;
          state_d       = REPORT;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          if (false_alarms_q != {FA_W{1'b1}}) false_alarms_d = false_alarms_q + FA_W'(1);
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      REPORT: begin
        if (rpt_ready) state_d = LOCKED;
      end
      LOCKED: begin
        if (rearm) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    dl_bcast_d      = (state_d != IDLE);
    origin_vec_d    = (state_d == ORIGIN) ? (PROC_NUM'(1) << cand_d) : '0;
    rpt_valid_d     = (state_d == REPORT);
    deadlock_flag_d = (state_d == LOCKED);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      cand_q          <= '0;
      timer_q         <= '0;
      cyc_q           <= '0;
      false_alarms_q  <= '0;
      rpt_proc_id_q   <= '0;
      rpt_cycle_q     <= '0;
      dl_bcast_q      <= 1'b0;
      origin_vec_q    <= '0;
      rpt_valid_q     <= 1'b0;
      deadlock_flag_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cand_q          <= cand_d;
      timer_q         <= timer_d;
      cyc_q           <= cyc_d;
      false_alarms_q  <= false_alarms_d;
      rpt_proc_id_q   <= rpt_proc_id_d;
      rpt_cycle_q     <= rpt_cycle_d;
      dl_bcast_q      <= dl_bcast_d;
      origin_vec_q    <= origin_vec_d;
      rpt_valid_q     <= rpt_valid_d;
      deadlock_flag_q <= deadlock_flag_d;
    end
  end

  assign dl_bcast      = dl_bcast_q;
  assign origin_vec    = origin_vec_q;
  assign rpt_valid     = rpt_valid_q;
  assign rpt_proc_id   = rpt_proc_id_q;
  assign rpt_cycle     = rpt_cycle_q;
  assign deadlock_flag = deadlock_flag_q;
  assign false_alarms  = false_alarms_q;

endmodule

// File: tb/tb_blk_1c3d32.sv
// Directed bench for blk_1c3d32: confirmation, timeout, back-pressure, race,
// rearm and reset behaviour against hand-computed expectations.
module tb_blk_1c3d32;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  dl_in_vec;
  logic        dl_bcast;
  logic [3:0]  origin_vec;
  logic        token_clear;
  logic        rpt_valid;
  logic        rpt_ready;
  logic [1:0]  rpt_proc_id;
  logic [31:0] rpt_cycle;
  logic        deadlock_flag;
  logic [7:0]  false_alarms;
  logic        rearm;

  int checks = 0;
  int errors = 0;
  int exp_fa = 0;
  logic [31:0] tb_cyc;
  logic [31:0] exp_cyc;

  blk_1c3d32 dut (
    .clock(clock), .reset(reset), .dl_in_vec(dl_in_vec), .dl_bcast(dl_bcast),
    .origin_vec(origin_vec), .token_clear(token_clear), .rpt_valid(rpt_valid),
    .rpt_ready(rpt_ready), .rpt_proc_id(rpt_proc_id), .rpt_cycle(rpt_cycle),
    .deadlock_flag(deadlock_flag), .false_alarms(false_alarms), .rearm(rearm)
  );

  always #5 clock = ~clock;

  // Reference cycle stamp
  always @(posedge clock) begin
    if (reset) tb_cyc <= 32'd0;
    else       tb_cyc <= tb_cyc + 32'd1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive a detection of dl pattern and advance into ORIGIN then first WAIT cycle.
  task automatic enter_wait(input logic [3:0] pat, input logic [3:0] exp_origin);
    dl_in_vec = pat;
    tick();
    checks++;
    if (origin_vec !== exp_origin || dl_bcast !== 1'b1) begin
      errors++;
      $display("FAIL origin: origin_vec=%b bcast=%b required origin_vec=%b bcast=1", origin_vec, dl_bcast, exp_origin);
    end
    dl_in_vec = 4'b0000;
    tick();
  endtask

  task automatic test_reset_state();
    checks++;
    if (dl_bcast !== 1'b0 || origin_vec !== 4'b0 || rpt_valid !== 1'b0 || deadlock_flag !== 1'b0 ||
        false_alarms !== 8'd0 || rpt_proc_id !== 2'd0 || rpt_cycle !== 32'd0 || token_clear !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: bcast=%b origin=%b valid=%b flag=%b fa=%0d id=%0d cyc=%0d tc=%b required all 0",
               dl_bcast, origin_vec, rpt_valid, deadlock_flag, false_alarms, rpt_proc_id, rpt_cycle, token_clear);
    end
  endtask

  task automatic test_confirm();
    enter_wait(4'b0110, 4'b0010);
    for (int c = 1; c < 5; c++) tick();
    checks++;
    if (token_clear !== 1'b0 || origin_vec !== 4'b0 || dl_bcast !== 1'b1) begin
      errors++;
      $display("FAIL wait_idle: tc=%b origin=%b bcast=%b required tc=0 origin=0000 bcast=1", token_clear, origin_vec, dl_bcast);
    end
    dl_in_vec = 4'b0010;
    #1;
    exp_cyc = tb_cyc;
    checks++;
    if (token_clear !== 1'b1) begin
      errors++;
      $display("FAIL token_clear: got %b required 1", token_clear);
    end
    tick();
    dl_in_vec = 4'b0000;
    #1;
    checks++;
    if (rpt_valid !== 1'b1 || rpt_proc_id !== 2'd1 || rpt_cycle !== exp_cyc || token_clear !== 1'b0) begin
      errors++;
      $display("FAIL report: valid=%b id=%0d cyc=%0d tc=%b required valid=1 id=1 cyc=%0d tc=0",
               rpt_valid, rpt_proc_id, rpt_cycle, token_clear, exp_cyc);
    end
  endtask

  task automatic test_back_pressure();
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (rpt_valid !== 1'b1 || rpt_proc_id !== 2'd1 || rpt_cycle !== exp_cyc || deadlock_flag !== 1'b0) begin
        errors++;
        $display("FAIL back_pressure[%0d]: valid=%b id=%0d cyc=%0d flag=%b required 1/1/%0d/0",
                 c, rpt_valid, rpt_proc_id, rpt_cycle, deadlock_flag, exp_cyc);
      end
    end
    rpt_ready = 1'b1;
    tick();
    rpt_ready = 1'b0;
    checks++;
    if (rpt_valid !== 1'b0 || deadlock_flag !== 1'b1 || dl_bcast !== 1'b1) begin
      errors++;
      $display("FAIL locked: valid=%b flag=%b bcast=%b required 0/1/1", rpt_valid, deadlock_flag, dl_bcast);
    end
    rearm = 1'b1;
    tick();
    rearm = 1'b0;
    checks++;
    if (deadlock_flag !== 1'b0 || dl_bcast !== 1'b0) begin
      errors++;
      $display("FAIL rearm_locked: flag=%b bcast=%b required 0/0", deadlock_flag, dl_bcast);
    end
  endtask

  task automatic test_race();
    enter_wait(4'b1100, 4'b0100);
    // Non-candidate bits must not confirm
    dl_in_vec = 4'b1011;
    #1;
    checks++;
    if (token_clear !== 1'b0) begin
      errors++;
      $display("FAIL non_cand: token_clear=%b required 0", token_clear);
    end
    for (int c = 2; c <= 64; c++) tick();
    dl_in_vec = 4'b0100;
    #1;
    exp_cyc = tb_cyc;
    checks++;
    if (token_clear !== 1'b1 || dl_bcast !== 1'b1) begin
      errors++;
      $display("FAIL race_tc: token_clear=%b bcast=%b required 1/1", token_clear, dl_bcast);
    end
    tick();
    dl_in_vec = 4'b0000;
    checks++;
    if (rpt_valid !== 1'b1 || rpt_proc_id !== 2'd2 || rpt_cycle !== exp_cyc || false_alarms !== 8'(exp_fa)) begin
      errors++;
      $display("FAIL race_report: valid=%b id=%0d cyc=%0d fa=%0d required 1/2/%0d/%0d",
               rpt_valid, rpt_proc_id, rpt_cycle, false_alarms, exp_cyc, exp_fa);
    end
    rpt_ready = 1'b1;
    tick();
    rpt_ready = 1'b0;
    rearm = 1'b1;
    tick();
    rearm = 1'b0;
  endtask

  task automatic test_rearm();
    enter_wait(4'b1000, 4'b1000);
    rearm = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    rearm = 1'b0;
    checks++;
    if (dl_bcast !== 1'b1 || deadlock_flag !== 1'b0) begin
      errors++;
      $display("FAIL rearm_wait: bcast=%b flag=%b required 1/0", dl_bcast, deadlock_flag);
    end
    dl_in_vec = 4'b1000;
    tick();
    dl_in_vec = 4'b0000;
    rpt_ready = 1'b1;
    tick();
    rpt_ready = 1'b0;
    checks++;
    if (deadlock_flag !== 1'b1 || rpt_proc_id !== 2'd3) begin
      errors++;
      $display("FAIL rearm_lock: flag=%b id=%0d required 1/3", deadlock_flag, rpt_proc_id);
    end
    // Detections are ignored while locked
    dl_in_vec = 4'b0001;
    tick();
    checks++;
    if (origin_vec !== 4'b0000 || deadlock_flag !== 1'b1) begin
      errors++;
      $display("FAIL locked_ignore: origin=%b flag=%b required 0000/1", origin_vec, deadlock_flag);
    end
    dl_in_vec = 4'b0000;
    rearm = 1'b1;
    tick();
    rearm = 1'b0;
    enter_wait(4'b0001, 4'b0001);
    for (int c = 2; c <= 65; c++) tick();
    exp_fa++;
    checks++;
    if (dl_bcast !== 1'b0 || false_alarms !== 8'(exp_fa)) begin
      errors++;
      $display("FAIL rearm_new: bcast=%b fa=%0d required 0/%0d", dl_bcast, false_alarms, exp_fa);
    end
  endtask

  task automatic test_timeout();
    for (int n = 0; n < 300; n++) begin
      enter_wait(4'b1000, 4'b1000);
      for (int c = 2; c <= 64; c++) tick();
      if (n == 0) begin
        checks++;
        if (dl_bcast !== 1'b1) begin
          errors++;
          $display("FAIL wait64_bcast: got %b required 1", dl_bcast);
        end
      end
      tick();
      exp_fa = (exp_fa < 255) ? exp_fa + 1 : 255;
      checks++;
      if (dl_bcast !== 1'b0 || false_alarms !== 8'(exp_fa)) begin
        errors++;
        $display("FAIL timeout[%0d]: bcast=%b fa=%0d required 0/%0d", n, dl_bcast, false_alarms, exp_fa);
      end
    end
  endtask

  task automatic test_reset_mid_report();
    enter_wait(4'b0100, 4'b0100);
    dl_in_vec = 4'b0100;
    tick();
    dl_in_vec = 4'b0000;
    checks++;
    if (rpt_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_report: valid=%b required 1", rpt_valid);
    end
    reset = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    test_reset_state();
    reset = 1'b0;
    tick();
    exp_fa = 0;
    checks++;
    if (dl_bcast !== 1'b0 || rpt_valid !== 1'b0 || false_alarms !== 8'd0 || deadlock_flag !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: bcast=%b valid=%b fa=%0d flag=%b required 0/0/0/0",
               dl_bcast, rpt_valid, false_alarms, deadlock_flag);
    end
    enter_wait(4'b0010, 4'b0010);
  endtask

  initial begin
    reset     = 1'b1;
    dl_in_vec = 4'b0000;
    rpt_ready = 1'b0;
    rearm     = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    test_reset_state();
    reset = 1'b0;
    tick();
    test_confirm();
    test_back_pressure();
    test_race();
    test_rearm();
    test_timeout();
    test_reset_mid_report();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
